// File: rtl/result_collector_pkg.sv
// Shared widths, FIFO geometry defaults and FSM encoding for the result collector.
package result_collector_pkg;

  localparam int RC_DATA_W = 21;
  localparam int RC_DEPTH  = 16;
  localparam int RC_ADDR_W = 4;
  localparam int RC_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DRAIN   = 2'd2,
    ST_DONE    = 2'd3
  } rc_state_e;

endpackage

// File: rtl/result_collector_sync_fifo.sv
// Show-ahead synchronous FIFO with wrap-bit pointers, flush and synchronous active-low reset.
module sync_fifo
  import result_collector_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int DEPTH  = RC_DEPTH,
  parameter int ADDR_W = RC_ADDR_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] data_o,
  output logic              full_o,
  output logic              empty_o
);

  localparam logic [ADDR_W:0] PTR_ONE = 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W:0]   wrPtr_q, wrPtr_d;
  logic [ADDR_W:0]   rdPtr_q, rdPtr_d;
  logic [DATA_W-1:0] lastData_q, lastData_d;
  logic [DATA_W-1:0] headData;
  logic              wrEn;
  logic              rdEn;

  assign full_o  = (wrPtr_q[ADDR_W] != rdPtr_q[ADDR_W]) &&
                   (wrPtr_q[ADDR_W-1:0] == rdPtr_q[ADDR_W-1:0]);
  assign empty_o = (wrPtr_q == rdPtr_q);

  // A pop frees the slot the push lands in, so full plus pop still accepts.
  assign rdEn = pop_i & ~empty_o;
  assign wrEn = push_i & (~full_o | rdEn);

  assign headData = mem_q[rdPtr_q[ADDR_W-1:0]];
  // While empty, keep showing the last word handed out so the output holds still.
  assign data_o   = empty_o ? lastData_q : headData;

  always_comb begin
    wrPtr_d    = wrPtr_q;
    rdPtr_d    = rdPtr_q;
    lastData_d = lastData_q;
    if (flush_i) begin
      wrPtr_d    = '0;
      rdPtr_d    = '0;
      lastData_d = '0;
    end else begin
      if (wrEn) begin
        wrPtr_d = wrPtr_q + PTR_ONE;
      end
      if (rdEn) begin
        rdPtr_d    = rdPtr_q + PTR_ONE;
        lastData_d = headData;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wrPtr_q    <= '0;
      rdPtr_q    <= '0;
      lastData_q <= '0;
    end else begin
      wrPtr_q    <= wrPtr_d;
      rdPtr_q    <= rdPtr_d;
      lastData_q <= lastData_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_ni && !flush_i && wrEn) begin
      mem_q[wrPtr_q[ADDR_W-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/result_collector.sv
// Collects accelerator result words into a FIFO, frames them on the acc_done rising edge
// and drains them to a valid/ready consumer, flagging frame_done once a frame is delivered.
module result_collector
  import result_collector_pkg::*;
#(
  parameter int DATA_W = RC_DATA_W,
  parameter int DEPTH  = RC_DEPTH,
  parameter int ADDR_W = RC_ADDR_W,
  parameter int CNT_W  = RC_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_req,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              acc_done,
  input  logic              clear,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [CNT_W-1:0]  count,
  output logic              overflow,
  output logic              frame_done
);

  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  rc_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             accDonePrev_q, accDonePrev_d;

  logic fifoFull;
  logic fifoEmpty;
  logic pop;
  logic push;
  logic drop;
  logic doneRise;

  assign pop      = ~fifoEmpty & rd_ready;
  assign push     = wr_req & (~fifoFull | pop);
  assign drop     = wr_req & fifoFull & ~pop;
  assign doneRise = acc_done & ~accDonePrev_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst),
    .flush_i (clear),
    .push_i  (wr_req),
    .data_i  (wr_data),
    .pop_i   (rd_ready),
    .data_o  (rd_data),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign rd_valid = ~fifoEmpty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // A word arriving alongside the end-of-frame edge belongs to the closing frame.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (doneRise) begin
            state_d = wr_req ? ST_DRAIN : ST_DONE;
          end else if (wr_req) begin
            state_d = ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (doneRise) begin
            state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (fifoEmpty && !push) begin
            state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          if (wr_req) begin
            state_d = doneRise ? ST_DRAIN : ST_COLLECT;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    frame_done = (state_q == ST_DONE);
  end

  always_comb begin
    count_d       = count_q;
    overflow_d    = overflow_q;
    accDonePrev_d = acc_done;
    if (clear) begin
      count_d       = '0;
      overflow_d    = 1'b0;
      accDonePrev_d = 1'b0;
    end else begin
      if (drop) begin
        overflow_d = 1'b1;
      end
      if (push) begin
        if (state_q == ST_DONE) begin
          count_d = CNT_ONE;
        end else if (count_q != '1) begin
          count_d = count_q + CNT_ONE;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q       <= '0;
      overflow_q    <= 1'b0;
      accDonePrev_q <= 1'b0;
    end else begin
      count_q       <= count_d;
      overflow_q    <= overflow_d;
      accDonePrev_q <= accDonePrev_d;
    end
  end

  assign count    = count_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_result_collector.sv
// Scenario-driven bench for result_collector; a negedge monitor checks every popped word
// against a scoreboard queue filled as writes are driven.
module tb_result_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [20:0] wr_data;
  logic        acc_done;
  logic        clear;
  logic        rd_valid;
  logic [20:0] rd_data;
  logic        rd_ready;
  logic [7:0]  count;
  logic        overflow;
  logic        frame_done;

  int          compared   = 0;
  int          mismatched = 0;
  logic [20:0] sb [$];
  logic [20:0] expWord;

  always #5 clk = ~clk;

  result_collector dut (
    .clk        (clk),
    .rst        (rst),
    .wr_req     (wr_req),
    .wr_data    (wr_data),
    .acc_done   (acc_done),
    .clear      (clear),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .count      (count),
    .overflow   (overflow),
    .frame_done (frame_done)
  );

  // Pops happen at the next rising edge; check the head word half a cycle before it.
  always @(negedge clk) begin
    if (rst && !clear && rd_valid && rd_ready) begin
      compared++;
      if (sb.size() == 0) begin
        mismatched++;
        $display("[TB] FAIL pop_unexpected: got word %h, required no word", rd_data);
      end else begin
        expWord = sb.pop_front();
        if (rd_data !== expWord) begin
          mismatched++;
          $display("[TB] FAIL pop_data: got %h, required %h", rd_data, expWord);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic w, input logic [20:0] d, input logic ad,
                               input logic rdy);
    wr_req   = w;
    wr_data  = d;
    acc_done = ad;
    rd_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    rst      = 1'b0;
    clear    = 1'b0;
    wr_req   = 1'b0;
    wr_data  = '0;
    acc_done = 1'b0;
    rd_ready = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    sb.delete();
  endtask

  task automatic test_reset();
    resetDut();
    compared++;
    if (rd_valid !== 1'b0) begin
      mismatched++; $display("[TB] FAIL reset_rd_valid: got %b, required 0", rd_valid);
    end
    compared++;
    if (rd_data !== 21'h0) begin
      mismatched++; $display("[TB] FAIL reset_rd_data: got %h, required 0", rd_data);
    end
    compared++;
    if (count !== 8'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL reset_flags: got count=%0d ovf=%b done=%b, required 0/0/0",
               count, overflow, frame_done);
    end
  endtask

  task automatic test_basic_frame();
    resetDut();
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(21'(i));
      applyStimulus(1'b1, 21'(i), 1'b0, 1'b1);
      compared++;
      if (rd_valid !== 1'b1 || rd_data !== 21'(i)) begin
        mismatched++;
        $display("[TB] FAIL basic_latency: got valid=%b data=%h, required 1/%h",
                 rd_valid, rd_data, 21'(i));
      end
    end
    compared++;
    if (count !== 8'd5) begin
      mismatched++; $display("[TB] FAIL basic_count: got %0d, required 5", count);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    compared++;
    if (frame_done !== 1'b0 || rd_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL basic_drain: got done=%b valid=%b, required 0/0", frame_done, rd_valid);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    compared++;
    if (frame_done !== 1'b1 || count !== 8'd5) begin
      mismatched++;
      $display("[TB] FAIL basic_done: got done=%b count=%0d, required 1/5", frame_done, count);
    end
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("[TB] FAIL basic_left: got %0d words pending, required 0", sb.size());
    end
  endtask

  task automatic test_overflow();
    resetDut();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(21'(32'h10000 + i));
      applyStimulus(1'b1, 21'(32'h10000 + i), 1'b0, 1'b0);
    end
    compared++;
    if (overflow !== 1'b1 || count !== 8'd16) begin
      mismatched++;
      $display("[TB] FAIL ovf_set: got ovf=%b count=%0d, required 1/16", overflow, count);
    end
    compared++;
    if (rd_valid !== 1'b1 || rd_data !== 21'h10000) begin
      mismatched++;
      $display("[TB] FAIL ovf_head: got valid=%b data=%h, required 1/10000", rd_valid, rd_data);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    compared++;
    if (sb.size() != 0 || rd_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL ovf_drain: got pending=%0d valid=%b, required 0/0", sb.size(), rd_valid);
    end
    compared++;
    if (overflow !== 1'b1) begin
      mismatched++; $display("[TB] FAIL ovf_sticky: got %b, required 1", overflow);
    end
  endtask

  task automatic test_full_pop();
    resetDut();
    for (int i = 0; i < 16; i++) begin
      sb.push_back(21'(32'h20 + i));
      applyStimulus(1'b1, 21'(32'h20 + i), 1'b0, 1'b0);
    end
    sb.push_back(21'h1FFFFF);
    applyStimulus(1'b1, 21'h1FFFFF, 1'b0, 1'b1);
    compared++;
    if (overflow !== 1'b0 || count !== 8'd17) begin
      mismatched++;
      $display("[TB] FAIL fullpop_accept: got ovf=%b count=%0d, required 0/17", overflow, count);
    end
    compared++;
    if (rd_data !== 21'h21) begin
      mismatched++; $display("[TB] FAIL fullpop_head: got %h, required 21", rd_data);
    end
    for (int i = 0; i < 16; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    compared++;
    if (sb.size() != 0 || rd_valid !== 1'b0 || rd_data !== 21'h1FFFFF) begin
      mismatched++;
      $display("[TB] FAIL fullpop_drain: got pending=%0d valid=%b data=%h, required 0/0/1fffff",
               sb.size(), rd_valid, rd_data);
    end
  endtask

  task automatic test_empty_frame();
    resetDut();
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0, '0, 1'b1, 1'b0);
      if (k == 0) begin
        compared++;
        if (frame_done !== 1'b1) begin
          mismatched++; $display("[TB] FAIL empty_first: got done=%b, required 1", frame_done);
        end
      end
    end
    compared++;
    if (frame_done !== 1'b1 || count !== 8'd0 || rd_valid !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL empty_hold: got done=%b count=%0d valid=%b, required 1/0/0",
               frame_done, count, rd_valid);
    end
    sb.push_back(21'h0ABCD);
    applyStimulus(1'b1, 21'h0ABCD, 1'b0, 1'b0);
    compared++;
    if (count !== 8'd1 || frame_done !== 1'b0 || rd_valid !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL empty_restart: got count=%0d done=%b valid=%b, required 1/0/1",
               count, frame_done, rd_valid);
    end
    applyStimulus(1'b0, '0, 1'b0, 1'b1);
    compared++;
    if (sb.size() != 0) begin
      mismatched++; $display("[TB] FAIL empty_left: got %0d pending, required 0", sb.size());
    end
  endtask

  task automatic test_done_same_cycle();
    int cycles;
    resetDut();
    sb.push_back(21'h0AAAA);
    applyStimulus(1'b1, 21'h0AAAA, 1'b0, 1'b1);
    sb.push_back(21'h05555);
    applyStimulus(1'b1, 21'h05555, 1'b1, 1'b1);
    compared++;
    if (count !== 8'd2 || frame_done !== 1'b0 || rd_data !== 21'h05555) begin
      mismatched++;
      $display("[TB] FAIL same_edge: got count=%0d done=%b data=%h, required 2/0/05555",
               count, frame_done, rd_data);
    end
    cycles = 0;
    while (frame_done !== 1'b1 && cycles < 10) begin
      applyStimulus(1'b0, '0, 1'b0, 1'b1);
      cycles++;
    end
    compared++;
    if (frame_done !== 1'b1 || cycles != 2) begin
      mismatched++;
      $display("[TB] FAIL same_done: got done=%b after %0d cycles, required 1 after 2",
               frame_done, cycles);
    end
    compared++;
    if (count !== 8'd2 || sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL same_final: got count=%0d pending=%0d, required 2/0", count, sb.size());
    end
  endtask

  task automatic test_flush(input bit useClear);
    resetDut();
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(21'(32'h300 + i));
      applyStimulus(1'b1, 21'(32'h300 + i), 1'b0, 1'b0);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b1);
    for (int i = 0; i < 12; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    compared++;
    if (sb.size() != 3 || rd_valid !== 1'b1 || overflow !== 1'b1 || frame_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_pre%0d: got pending=%0d valid=%b ovf=%b done=%b, required 3/1/1/0",
               useClear, sb.size(), rd_valid, overflow, frame_done);
    end
    sb.delete();
    if (useClear) clear = 1'b1;
    else          rst   = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, 1'b0);
    clear = 1'b0;
    rst   = 1'b1;
    compared++;
    if (rd_valid !== 1'b0 || count !== 8'd0 || overflow !== 1'b0 || frame_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_state%0d: got valid=%b count=%0d ovf=%b done=%b, required 0/0/0/0",
               useClear, rd_valid, count, overflow, frame_done);
    end
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, '0, 1'b0, 1'b1);
    compared++;
    if (rd_valid !== 1'b0 || frame_done !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL flush_idle%0d: got valid=%b done=%b, required 0/0",
               useClear, rd_valid, frame_done);
    end
    applyStimulus(1'b0, '0, 1'b1, 1'b0);
    compared++;
    if (frame_done !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL flush_empty%0d: got done=%b, required 1", useClear, frame_done);
    end
  endtask

  initial begin
    test_reset();
    test_basic_frame();
    test_overflow();
    test_full_pop();
    test_empty_frame();
    test_done_same_cycle();
    test_flush(1'b0);
    test_flush(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/result_collector.md
Name: result_collector

Overview:
Receive end of the accelerator result-write interface (wr_req / wr_data, 21-bit). Captures each result word into an internal FIFO and counts the words in the current frame. Frames the result stream using the accelerator's done pulse. Drains the words to a downstream consumer over a valid/ready handshake and asserts frame_done once a frame has been fully delivered.

Parameters:
DATA_W, 21, width of a result word (matches accelerator wr_data)
DEPTH, 16, FIFO depth in words (power of two)
ADDR_W, 4, log2(DEPTH)
CNT_W, 8, width of the per-frame word counter

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset (rst=0 at a rising edge resets the block)
wr_req  in  1  accelerator write strobe, one word per cycle, no backpressure
wr_data  in  DATA_W  accelerator result word, valid when wr_req=1
acc_done  in  1  accelerator done; the rising edge marks end of frame
clear  in  1  synchronous flush: empties the FIFO, zeroes count/overflow, goes to IDLE
rd_valid  out  1  head word available
rd_data  out  DATA_W  FIFO head word (show-ahead)
rd_ready  in  1  consumer accepts the head word when rd_valid=1
count  out  CNT_W  words accepted in current frame, saturating
overflow  out  1  sticky: a write was dropped because the FIFO was full
frame_done  out  1  high in DONE state

Behaviour:
- Reset (rst=0): FIFO empty, rd_valid=0, rd_data=0, count=0, overflow=0, frame_done=0, state=IDLE, acc_done edge detector cleared.
- clear=1 has the same effect as reset, except that rst has priority. It overrides all other inputs in that cycle.
- acc_done is edge-detected internally (registered previous value). A level held high generates only one end-of-frame event.
- Write: wr_req=1 and FIFO not full means the word is stored at the edge.
  - rd_valid goes high on the next cycle (1-cycle write-to-read latency).
  - count increments by 1 and saturates at 2^CNT_W-1.
- Full: wr_req=1 with FIFO full and no pop in the same cycle means the word is dropped, overflow is set (sticky), and count is unchanged.
  - Full plus a simultaneous pop (rd_valid & rd_ready): both happen and the write is accepted.
- Read: a pop occurs when rd_valid & rd_ready. rd_data shows the next head on the following cycle.
  - rd_data holds its value while rd_valid=0 or rd_ready=0.
- Simultaneous push and pop on an empty FIFO: the push is stored and there is no pop, because rd_valid was 0.
- Pointers: ADDR_W+1 bits each, wrapping modulo 2*DEPTH.
  - Full when the MSBs differ and the rest are equal.
  - Empty when the pointers are equal.
- States:
  - IDLE: wr_req goes to COLLECT, and that first word is accepted.
  - IDLE: an acc_done edge with no words goes straight to DONE (an empty frame).
  - COLLECT: accepts words. An acc_done edge goes to DRAIN. A word arriving in the same cycle as the edge is accepted and counted.
  - DRAIN: writes are still accepted. When the FIFO is empty and there is no push this cycle, go to DONE.
  - DONE: frame_done=1 and count is frozen. wr_req starts a new frame: go to COLLECT, set count=1, frame_done=0. overflow is retained.
- Reset or clear during COLLECT or DRAIN discards buffered words. No further rd_valid is driven for them.

Decomposition:
- Shared package: DATA_W=21, state encoding (IDLE, COLLECT, DRAIN, DONE; 2-bit), DEPTH and ADDR_W defaults.
- One sub-module, sync_fifo: parameterised DATA_W/ADDR_W, show-ahead, with full/empty outputs and synchronous active-low reset plus flush input.
- The FSM, counter, edge detector and overflow flag stay in result_collector.

Test Plan:
- Reset then 5 consecutive writes 0x00001..0x00005 with rd_ready=1, then an acc_done pulse → rd_data sequence 1..5, each 1 cycle after its write; count=5; frame_done=1 two cycles after the last pop.
- rd_ready=0, 17 writes 0x10000+i → the first 16 are stored, the 17th is dropped, overflow=1, count=16. Then rd_ready=1 → 16 words 0x10000..0x1000F in order, and overflow stays 1.
- FIFO full, then wr_req=1 and a pop in the same cycle with data 0x1FFFFF → the write is accepted, no overflow, and the word appears as the 16th after the current head.
- acc_done held high for 10 cycles in IDLE with no writes → DONE, count=0, frame_done=1. A later wr_req gives count=1 and frame_done=0.
- wr_req and the acc_done rising edge in the same cycle → the word is counted and delivered, and the state passes through DRAIN to DONE.
- Mid-DRAIN with 3 words buffered, assert rst=0 for one cycle (and separately clear=1) → rd_valid=0, count=0, overflow=0, IDLE next cycle, no stale words emitted.
